// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bundle for the register file.
// master drives addresses, write, issue and flush; slave returns read data, busy bits and busy_cnt.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              flush;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rs_addr, rt_addr, we, wa, wd,
    output issue_en, issue_addr, flush,
    input  rs_data, rt_data, rs_busy, rt_busy,
    input  busy_cnt
  );

  modport slave (
    input  rs_addr, rt_addr, we, wa, wd,
    input  issue_en, issue_addr, flush,
    output rs_data, rt_data, rs_busy, rt_busy,
    output busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with per-register busy scoreboard and registered busy count.
// Ports: clk, rst_n (async low), rf (regfile_sb_if.slave); REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic wr_ok;
  logic iss_ok;
  logic zr_rs;
  logic zr_rt;
  logic byp_rs;
  logic byp_rt;

  assign wr_ok  = rf.we &&
                  !((ZERO_REG != 0) && (rf.wa == '0));
  assign iss_ok = rf.issue_en &&
                  !((ZERO_REG != 0) && (rf.issue_addr == '0));

  assign zr_rs = (ZERO_REG != 0) && (rf.rs_addr == '0);
  assign zr_rt = (ZERO_REG != 0) && (rf.rt_addr == '0);

`ifdef REGFILE_BYPASS_EN
  assign byp_rs = wr_ok && (rf.rs_addr == rf.wa);
  assign byp_rt = wr_ok && (rf.rt_addr == rf.wa);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif

  assign rf.rs_data = zr_rs  ? '0 :
                      byp_rs ? rf.wd :
                      regs_q[rf.rs_addr];
  assign rf.rt_data = zr_rt  ? '0 :
                      byp_rt ? rf.wd :
                      regs_q[rf.rt_addr];

  // A bypassed write clears busy now; a same-edge issue shows up next cycle.
  assign rf.rs_busy = !zr_rs && !byp_rs &&
                      busy_q[rf.rs_addr];
  assign rf.rt_busy = !zr_rt && !byp_rt &&
                      busy_q[rf.rt_addr];

  assign rf.busy_cnt = cnt_q;

  // Issue after write so the newer producer wins; flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)
      busy_d[rf.wa] = 1'b0;
    if (iss_ok)
      busy_d[rf.issue_addr] = 1'b1;
    if (rf.flush)
      busy_d = '0;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok)
        regs_q[rf.wa] <= rf.wd;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array model.
// Two instances: default 32x32 with zero register, and 16-bit x 8 without.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bif ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) sif ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf(bif.slave)
  );
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .rf(sif.slave)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] mem [32];
  bit          bsy [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (bsy[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYP && bif.we && bif.wa == a) return bif.wd;
    return mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (BYP && bif.we && bif.wa == a) return 1'b0;
    return bsy[a];
  endfunction

  task automatic drv(input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic ie,
                     input logic [4:0] ia, input logic fl,
                     input logic [4:0] rs, input logic [4:0] rt);
    bif.we = w; bif.wa = a; bif.wd = d;
    bif.issue_en = ie; bif.issue_addr = ia;
    bif.flush = fl;
    bif.rs_addr = rs; bif.rt_addr = rt;
  endtask

  task automatic chk_rd(input string tag);
    #1;
    chk({tag, "_rsd"}, bif.rs_data, m_data(bif.rs_addr));
    chk({tag, "_rtd"}, bif.rt_data, m_data(bif.rt_addr));
    chk({tag, "_rsb"}, bif.rs_busy, m_busy(bif.rs_addr));
    chk({tag, "_rtb"}, bif.rt_busy, m_busy(bif.rt_addr));
  endtask

  // Apply the edge rules to the model, then check busy_cnt.
  task automatic tick(input string tag);
    @(posedge clk);
    if (bif.we && bif.wa != 0) begin
      mem[bif.wa] = bif.wd;
      bsy[bif.wa] = 1'b0;
    end
    if (bif.issue_en && bif.issue_addr != 0)
      bsy[bif.issue_addr] = 1'b1;
    if (bif.flush)
      for (int i = 0; i < 32; i++) bsy[i] = 1'b0;
    #1;
    chk({tag, "_cnt"}, bif.busy_cnt, m_cnt());
  endtask

  initial begin
    m_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    sif.we = 0; sif.wa = 0; sif.wd = 0;
    sif.issue_en = 0; sif.issue_addr = 0; sif.flush = 0;
    sif.rs_addr = 0; sif.rt_addr = 0;
    #12 rst_n = 1'b1;
    chk_rd("rst");
    chk("rst_cnt", bif.busy_cnt, 0);

    // load r5, issue r6, then async reset mid-cycle
    drv(1, 5, 32'hDEADBEEF, 1, 6, 0, 5, 6);
    tick("ld");
    drv(0, 0, 0, 0, 0, 0, 5, 6);
    chk_rd("ld");
    chk("ld_r5", bif.rs_data, 32'hDEADBEEF);
    chk("ld_b6", bif.rt_busy, 1);
    drv(1, 8, 32'h1111, 0, 0, 0, 5, 6);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_d5", bif.rs_data, 0);
    chk("arst_b6", bif.rt_busy, 0);
    chk("arst_cnt", bif.busy_cnt, 0);
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 0, 0, 8, 5);
    #3 rst_n = 1'b1;
    chk_rd("arst");
    chk("arst_r8", bif.rs_data, 0);
    @(posedge clk);
    #1;

    // write/read and zero register
    drv(1, 3, 32'h12345678, 0, 0, 0, 0, 0);
    tick("wr");
    drv(0, 0, 0, 0, 0, 0, 3, 3);
    chk_rd("wr");
    chk("wr_rs", bif.rs_data, 32'h12345678);
    chk("wr_rt", bif.rt_data, 32'h12345678);
    drv(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    chk_rd("z");
    tick("z");
    drv(0, 0, 0, 0, 0, 0, 0, 3);
    chk_rd("z");
    chk("z_d", bif.rs_data, 0);
    chk("z_b", bif.rs_busy, 0);
    chk("z_cnt", bif.busy_cnt, 0);

    // scoreboard
    drv(0, 0, 0, 1, 7, 0, 7, 0);
    tick("sb");
    chk("sb_cnt1", bif.busy_cnt, 1);
    drv(0, 0, 0, 0, 0, 0, 7, 7);
    chk_rd("sb");
    chk("sb_b7", bif.rs_busy, 1);
    drv(1, 7, 32'h11, 0, 0, 0, 7, 7);
    chk_rd("sbw");
    tick("sbw");
    chk("sbw_cnt0", bif.busy_cnt, 0);
    drv(1, 7, 32'h22, 1, 7, 0, 7, 3);
    chk_rd("sbiw");
    tick("sbiw");
    drv(0, 0, 0, 0, 0, 0, 7, 7);
    chk_rd("sbiw");
    chk("sbiw_b", bif.rs_busy, 1);
    chk("sbiw_d", bif.rs_data, 32'h22);
    chk("sbiw_cnt", bif.busy_cnt, 1);
    drv(1, 7, 32'h22, 0, 0, 0, 7, 7);
    tick("clr7");

    // flush beats a same-edge issue
    for (int i = 1; i <= 3; i++) begin
      drv(0, 0, 0, 1, 5'(i), 0, 1, 2);
      tick("fl_iss");
    end
    chk("fl_cnt3", bif.busy_cnt, 3);
    drv(0, 0, 0, 1, 4, 1, 4, 1);
    tick("fl");
    chk_rd("fl");
    chk("fl_cnt0", bif.busy_cnt, 0);
    chk("fl_b4", bif.rs_busy, 0);

    // forwarding behaviour of a write to a busy register
    drv(0, 0, 0, 1, 9, 0, 9, 9);
    tick("by_iss");
    drv(1, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 9);
    #1;
    if (BYP) begin
      chk("by_d", bif.rs_data, 32'hA5A5A5A5);
      chk("by_b", bif.rs_busy, 0);
    end else begin
      chk("nby_d", bif.rs_data, 0);
      chk("nby_b", bif.rs_busy, 1);
    end
    tick("by");
    drv(0, 0, 0, 0, 0, 0, 9, 9);
    chk_rd("by_nx");
    chk("by_nx_d", bif.rs_data, 32'hA5A5A5A5);
    chk("by_nx_b", bif.rs_busy, 0);
    drv(1, 9, 32'h5A5A5A5A, 1, 9, 0, 9, 9);
    chk_rd("byi");
    tick("byi");
    drv(0, 0, 0, 0, 0, 0, 9, 9);
    chk_rd("byi_nx");
    chk("byi_nx_b", bif.rs_busy, 1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 1) == 1,
          5'($urandom_range(0, 31)), $urandom,
          $urandom_range(0, 9) < 4,
          5'($urandom_range(0, 31)),
          $urandom_range(0, 19) == 0,
          5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)));
      chk_rd("rnd");
      tick("rnd");
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // narrow instance: r0 is ordinary, count reaches 8
    sif.we = 1; sif.wa = 0; sif.wd = 16'hBEEF;
    @(posedge clk);
    #1;
    sif.we = 0; sif.rs_addr = 0; sif.rt_addr = 7;
    #1;
    chk("s_r0", sif.rs_data, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      sif.issue_en = 1; sif.issue_addr = 3'(i);
      @(posedge clk);
      #1;
    end
    sif.issue_en = 0;
    #1;
    chk("s_cnt8", sif.busy_cnt, 8);
    chk("s_b0", sif.rs_busy, 1);
    chk("s_b7", sif.rt_busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
